ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit that reads the PC register each cycle and turns it into an instruction-memory transaction. It issues one request per PC over a valid/ready channel, waits for the response, buffers it, and presents the PC/instruction pair to decode. It drives the stall request that freezes the PC register until the current PC's instruction is captured. It squashes in-flight work on an execute-stage redirect.

## Interface
- RESET_PC, 64'h80000000, reset value of fetch_o_pc; matches the PC register reset value.
- NOP_INSTR, 32'h00000013, instruction word shown on fetch_o_instr when the output is empty.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pc  in  64  current PC register value.
- execute_i_need_jump  in  1  redirect from execute; squashes all fetch state.
- regD_stall  in  1  decode is not accepting; the output must hold.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  request address.
- imem_rsp_valid  in  1  response valid; there is no backpressure.
- imem_rsp_data  in  32  instruction word.
- fetch_o_valid  out  1  output slot holds a live instruction.
- fetch_o_pc  out  64  PC of the output instruction.
- fetch_o_instr  out  32  output instruction word.
- fetch_o_pre_pc  out  64  next sequential PC, combinational pc + 4; feeds the PC register.
- fetch_o_stall_req  out  1  holds the PC register.

## Operation
- At most one outstanding memory request.
- Output slot OUT holds valid/pc/instr. A skid buffer SKID holds pc/instr.
- OUT is consumed in a cycle where fetch_o_valid=1 and regD_stall=0. OUT is free when it is empty or being consumed.
- States:
  - IDLE: imem_req_valid=1 and imem_req_addr=pc. This is suppressed (valid=0) during rst and while execute_i_need_jump=1. A handshake latches req_pc=pc and moves to WAIT.
  - WAIT: awaits imem_rsp_valid.
    - If a response arrives and OUT is free: capture it into OUT (fetch_o_pc=req_pc, fetch_o_valid=1 next cycle) and go to IDLE.
    - If a response arrives and OUT is not free: store it in SKID and go to HOLD.
  - HOLD: when OUT is consumed, move SKID into OUT and go to IDLE.
  - DRAIN: discard the next imem_rsp_valid, then go to IDLE.
- fetch_o_stall_req=0 only in:
  - the cycle the current PC's instruction moves into OUT (WAIT capture or HOLD transfer), so the PC advances to pre_pc; or
  - any cycle with execute_i_need_jump=1, so the PC loads the jump target.
  - Otherwise it is 1, including IDLE.
- Redirect (execute_i_need_jump=1), which has priority over everything else:
  - OUT and SKID are invalidated next cycle.
  - From WAIT without a response this cycle, go to DRAIN.
  - From WAIT with a response this cycle, drop the response and go to IDLE.
  - From HOLD or DRAIN, go to IDLE (DRAIN stays DRAIN if its response has not arrived).
  - From IDLE, stay in IDLE with no request issued.
- imem_rsp_valid in IDLE or HOLD (no outstanding request) is ignored.
- When OUT is consumed and nothing new is captured, fetch_o_valid goes to 0 and fetch_o_instr goes to NOP_INSTR.

## Timing
- Reset state: IDLE, fetch_o_valid=0, fetch_o_pc=RESET_PC, fetch_o_instr=NOP_INSTR, imem_req_valid=0 while rst=1, fetch_o_stall_req=1, SKID empty.
- Reset in any state, including WAIT or DRAIN, returns to IDLE. A later stray response is ignored.
- With a 1-cycle memory and no stalls:
  - cycle 0: request handshake.
  - cycle 1: response; stall_req=0.
  - cycle 2: fetch_o_valid=1 and pc updated; next request issued.
- Throughput is 1 instruction per 2 cycles. Latency from request to output is 2 cycles.
- imem_req_addr is stable while imem_req_valid=1 and ready=0, because pc is frozen by stall_req=1.
- A simultaneous redirect and response in WAIT discards the response; the next request goes to the jump target the following cycle.

## Test plan
- Reset, then pc=0x80000000, ready=1, response 1 cycle later with 0x00500093 -> cycle 2: fetch_o_valid=1, fetch_o_pc=0x80000000, fetch_o_instr=0x00500093; stall_req=0 only in cycle 1; fetch_o_pre_pc=0x80000004.
- ready held 0 for 3 cycles -> imem_req_addr constant, stall_req=1 throughout, no state change.
- OUT valid with regD_stall=1 when the response 0x00a00113 arrives -> goes to HOLD with stall_req=1; regD_stall drops -> OUT gets 0x00a00113 next cycle, stall_req=0 in the drop cycle.
- Redirect while in WAIT, response 2 cycles later -> response discarded, fetch_o_valid=0, next request address equals the new pc (jump target).
- Redirect in the same cycle as a response -> response dropped, stall_req=0 that cycle, IDLE next cycle.
- rst asserted in WAIT, response arrives after reset -> ignored; outputs at reset values; fresh request for RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch: turns the PC register into one imem request at a time, buffers the
// response in an output slot (plus a one-entry skid) and holds the PC until it is captured.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        execute_i_need_jump,
  input  logic        regD_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_o_valid,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  output logic [63:0] fetch_o_pre_pc,
  output logic        fetch_o_stall_req
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic out_consume;
  logic out_free;
  logic capture;

  assign out_consume = out_valid_q && !regD_stall;
  assign out_free    = !out_valid_q || out_consume;

  assign imem_req_valid = (state_q == StIdle) && !rst && !execute_i_need_jump;
  assign imem_req_addr  = pc;
  assign fetch_o_pre_pc = pc + 64'd4;

  // PC may move only when its instruction lands in OUT, or to load a jump target.
  assign fetch_o_stall_req = !(execute_i_need_jump || capture);

  assign fetch_o_valid = out_valid_q;
  assign fetch_o_pc    = out_pc_q;
  assign fetch_o_instr = out_instr_q;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    capture      = 1'b0;

    if (out_consume) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end

    case (state_q)
      StIdle: begin
        if (imem_req_valid && imem_req_ready) begin
          req_pc_d = pc;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (execute_i_need_jump) begin
          state_d = imem_rsp_valid ? StIdle : StDrain;
        end else if (imem_rsp_valid) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_instr_d = imem_rsp_data;
            capture     = 1'b1;
            state_d     = StIdle;
          end else begin
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rsp_data;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (execute_i_need_jump) begin
          state_d = StIdle;
        end else if (out_consume) begin
          out_valid_d = 1'b1;
          out_pc_d    = skid_pc_q;
          out_instr_d = skid_instr_q;
          capture     = 1'b1;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        // The squashed request's response is still owed; swallow it.
        if (imem_rsp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (execute_i_need_jump) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_pc_q     <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= RESET_PC;
      out_instr_q  <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit: one table row per clock cycle.
module tb_ifetch_unit;

  localparam logic [63:0] R   = 64'h8000_0000;
  localparam logic [63:0] J   = 64'h8000_1000;
  localparam logic [63:0] J2  = 64'h8000_2000;
  localparam logic [63:0] J3  = 64'h8000_3000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        jmp;
  logic        dstall;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        o_valid;
  logic [63:0] o_pc;
  logic [31:0] o_instr;
  logic [63:0] o_pre_pc;
  logic        o_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .execute_i_need_jump (jmp),
    .regD_stall          (dstall),
    .imem_req_valid      (req_valid),
    .imem_req_ready      (req_ready),
    .imem_req_addr       (req_addr),
    .imem_rsp_valid      (rsp_valid),
    .imem_rsp_data       (rsp_data),
    .fetch_o_valid       (o_valid),
    .fetch_o_pc          (o_pc),
    .fetch_o_instr       (o_instr),
    .fetch_o_pre_pc      (o_pre_pc),
    .fetch_o_stall_req   (o_stall)
  );

  typedef struct {
    logic        rst;
    logic        jmp;
    logic        dst;
    logic        rdy;
    logic        rv;
    logic [63:0] pc;
    logic [31:0] data;
    logic        e_rqv;
    logic        e_stl;
    logic        e_ov;
    logic [63:0] e_opc;
    logic [31:0] e_oin;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r, logic j, logic d, logic rdy, logic rv, logic [63:0] p,
                              logic [31:0] dat, logic rqv, logic stl, logic ov,
                              logic [63:0] opc, logic [31:0] oin);
    vec_t v;
    v.rst = r; v.jmp = j; v.dst = d; v.rdy = rdy; v.rv = rv; v.pc = p; v.data = dat;
    v.e_rqv = rqv; v.e_stl = stl; v.e_ov = ov; v.e_opc = opc; v.e_oin = oin;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    bit seen;

    //            rst j d r rv pc      data          rqv stl ov opc     oin
    // Reset and basic 1-cycle memory fetch
    vecs[0]  = mk(1, 0, 0, 1, 0, R,      32'h0,        0, 1, 0, R,      NOP);
    vecs[1]  = mk(0, 0, 0, 1, 0, R,      32'h0,        1, 1, 0, R,      NOP);
    vecs[2]  = mk(0, 0, 0, 1, 1, R,      32'h00500093, 0, 0, 0, R,      NOP);
    vecs[3]  = mk(0, 0, 0, 0, 0, R+4,    32'h0,        1, 1, 1, R,      32'h00500093);
    // ready low for three cycles: address and stall held
    vecs[4]  = mk(0, 0, 0, 0, 0, R+4,    32'h0,        1, 1, 0, R,      NOP);
    vecs[5]  = mk(0, 0, 0, 0, 0, R+4,    32'h0,        1, 1, 0, R,      NOP);
    vecs[6]  = mk(0, 0, 0, 1, 0, R+4,    32'h0,        1, 1, 0, R,      NOP);
    // Response while OUT is stalled -> HOLD, then transfer on release
    vecs[7]  = mk(0, 0, 0, 0, 1, R+4,    32'h00400013, 0, 0, 0, R,      NOP);
    vecs[8]  = mk(0, 0, 1, 1, 0, R+8,    32'h0,        1, 1, 1, R+4,    32'h00400013);
    vecs[9]  = mk(0, 0, 1, 0, 1, R+8,    32'h00a00113, 0, 1, 1, R+4,    32'h00400013);
    vecs[10] = mk(0, 0, 1, 0, 0, R+8,    32'h0,        0, 1, 1, R+4,    32'h00400013);
    vecs[11] = mk(0, 0, 0, 0, 0, R+8,    32'h0,        0, 0, 1, R+4,    32'h00400013);
    vecs[12] = mk(0, 0, 0, 0, 0, R+12,   32'h0,        1, 1, 1, R+8,    32'h00a00113);
    // Redirect in WAIT, response two cycles later is drained
    vecs[13] = mk(0, 0, 0, 1, 0, R+12,   32'h0,        1, 1, 0, R+8,    NOP);
    vecs[14] = mk(0, 1, 0, 1, 0, R+12,   32'h0,        0, 0, 0, R+8,    NOP);
    vecs[15] = mk(0, 0, 0, 1, 0, J,      32'h0,        0, 1, 0, R+8,    NOP);
    vecs[16] = mk(0, 0, 0, 1, 1, J,      32'hdeadbeef, 0, 1, 0, R+8,    NOP);
    vecs[17] = mk(0, 0, 0, 1, 0, J,      32'h0,        1, 1, 0, R+8,    NOP);
    // Redirect coincident with response
    vecs[18] = mk(0, 1, 0, 1, 1, J,      32'h11111111, 0, 0, 0, R+8,    NOP);
    vecs[19] = mk(0, 0, 0, 1, 0, J2,     32'h0,        1, 1, 0, R+8,    NOP);
    // Redirect in IDLE with a held OUT: no request, OUT invalidated
    vecs[20] = mk(0, 0, 0, 1, 1, J2,     32'h22222293, 0, 0, 0, R+8,    NOP);
    vecs[21] = mk(0, 1, 1, 1, 0, J2+4,   32'h0,        0, 0, 1, J2,     32'h22222293);
    vecs[22] = mk(0, 0, 0, 1, 0, J3,     32'h0,        1, 1, 0, J2,     NOP);
    // Reset in WAIT, stray response afterwards ignored
    vecs[23] = mk(1, 0, 0, 1, 0, J3,     32'h0,        0, 1, 0, J2,     NOP);
    vecs[24] = mk(0, 0, 0, 0, 1, R,      32'h33333333, 1, 1, 0, R,      NOP);
    vecs[25] = mk(0, 0, 0, 1, 0, R,      32'h0,        1, 1, 0, R,      NOP);

    rst = 1'b1; pc = R; jmp = 1'b0; dstall = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; jmp = vecs[i].jmp; dstall = vecs[i].dst;
      req_ready = vecs[i].rdy; rsp_valid = vecs[i].rv; pc = vecs[i].pc;
      rsp_data = vecs[i].data;
      #1;
      check("req_valid", i, 64'(req_valid), 64'(vecs[i].e_rqv));
      if (vecs[i].e_rqv) check("req_addr", i, req_addr, vecs[i].pc);
      check("stall_req", i, 64'(o_stall), 64'(vecs[i].e_stl));
      check("out_valid", i, 64'(o_valid), 64'(vecs[i].e_ov));
      check("out_pc", i, o_pc, vecs[i].e_opc);
      check("out_instr", i, 64'(o_instr), 64'(vecs[i].e_oin));
      check("pre_pc", i, o_pre_pc, vecs[i].pc + 64'd4);
    end

    // Request for RESET_PC is outstanding; answer it and wait (bounded) for the output.
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00000517;
    #1;
    check("final_stall", 100, 64'(o_stall), 64'd0);
    @(negedge clk);
    rsp_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      #1;
      if (o_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("final_seen", 101, 64'(seen), 64'd1);
    check("final_pc", 102, o_pc, R);
    check("final_instr", 103, 64'(o_instr), 64'h00000517);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
